ram_port_arbiter: RTL and testbench

- Shares one port of the dual-port tile RAM between two requesters: A (host/DMA loader) and B (compute fetch).
- Each request is a burst of 1..2^LENW beats from a base address, read or write.
- Arbitration is round-robin. The block auto-increments the address and returns read data with a valid strobe.
- Sits between the loaders/fetch units and the RAM's addr/d/we/q port; the RAM has 1-cycle registered read latency.

---
 rtl/ram_port_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one tile-RAM port between requester A (host/DMA
// loader) and requester B (compute fetch). Round-robin burst arbitration,
// address auto-increment and read-data return with a per-requester strobe.
// Optional build macro RAM_ARB_STATS_EN adds saturating 16-bit grant/wait
// counters as extra output ports.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no burst; sample req_a/req_b and grant at the next edge
// BURST | one beat per cycle at addr_q; ends after rem_q reaches zero
module ram_port_arbiter #(
  parameter int AWIDTH      = 10,
  parameter int DESIGN_SIZE = 16,
  parameter int DWIDTH      = 8,
  parameter int LENW        = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_a,
  input  logic                          req_b,
  input  logic                          we_a,
  input  logic                          we_b,
  input  logic [AWIDTH-1:0]             addr_a,
  input  logic [AWIDTH-1:0]             addr_b,
  input  logic [LENW-1:0]               len_a,
  input  logic [LENW-1:0]               len_b,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] wdata_a,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] wdata_b,
  input  logic [DESIGN_SIZE-1:0]        wmask_a,
  input  logic [DESIGN_SIZE-1:0]        wmask_b,
  output logic                          ack_a,
  output logic                          ack_b,
  output logic                          beat_a,
  output logic                          beat_b,
  output logic                          rvalid_a,
  output logic                          rvalid_b,
  output logic [DESIGN_SIZE*DWIDTH-1:0] rdata,
  output logic                          busy,
  output logic [AWIDTH-1:0]             ram_addr,
  output logic [DESIGN_SIZE*DWIDTH-1:0] ram_d,
  output logic [DESIGN_SIZE-1:0]        ram_we,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] ram_q
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [15:0]                   stat_grants_a,
  output logic [15:0]                   stat_grants_b,
  output logic [15:0]                   stat_wait
`endif
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;      // 0 = A owns the burst, 1 = B
  logic              ptr_q, ptr_d;      // 0 = A favoured on a tie, 1 = B
  logic              we_q, we_d;
  logic              first_q, first_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [LENW-1:0]   rem_q, rem_d;      // beats left after the current one
  logic              rvalid_a_q, rvalid_a_d;
  logic              rvalid_b_q, rvalid_b_d;
  logic              grant_a, grant_b;

  // Arbitration decision, only meaningful while idle.
  always_comb begin
    grant_a = (state_q == IDLE) && req_a && (!req_b || !ptr_q);
    grant_b = (state_q == IDLE) && req_b && (!req_a ||  ptr_q);
  end

  // Next-state: latch the granted request, then walk the burst down to zero.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    we_d       = we_q;
    first_d    = 1'b0;
    addr_d     = addr_q;
    rem_d      = rem_q;
    rvalid_a_d = 1'b0;
    rvalid_b_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_a || grant_b) begin
          state_d = BURST;
          gnt_d   = grant_b;
          we_d    = grant_b ? we_b   : we_a;
          addr_d  = grant_b ? addr_b : addr_a;
          rem_d   = grant_b ? len_b  : len_a;
          first_d = 1'b1;
        end
      end
      BURST: begin
        rvalid_a_d = !we_q && !gnt_q;
        rvalid_b_d = !we_q &&  gnt_q;
        addr_d     = addr_q + 1'b1;
        if (rem_q == '0) begin
          state_d = IDLE;
          ptr_d   = !gnt_q;
        end else begin
          rem_d = rem_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Burst state registers; reset aborts any burst and returns the pointer to A.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      ptr_q      <= 1'b0;
      we_q       <= 1'b0;
      first_q    <= 1'b0;
      addr_q     <= '0;
      rem_q      <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      we_q       <= we_d;
      first_q    <= first_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
    end
  end

  // RAM port and requester strobes. The RAM's own output register is the
  // read pipeline stage, so rdata is ram_q qualified by the return strobe.
  always_comb begin
    busy     = (state_q == BURST);
    beat_a   = busy && !gnt_q;
    beat_b   = busy &&  gnt_q;
    ack_a    = beat_a && first_q;
    ack_b    = beat_b && first_q;
    ram_addr = busy ? addr_q : '0;
    ram_we   = '0;
    ram_d    = '0;
    if (busy && we_q) begin
      ram_we = gnt_q ? wmask_b : wmask_a;
      ram_d  = gnt_q ? wdata_b : wdata_a;
    end
    rvalid_a = rvalid_a_q;
    rvalid_b = rvalid_b_q;
    rdata    = (rvalid_a_q || rvalid_b_q) ? ram_q : '0;
  end

`ifdef RAM_ARB_STATS_EN
  logic [15:0] grants_a_q, grants_a_d;
  logic [15:0] grants_b_q, grants_b_d;
  logic [15:0] wait_q, wait_d;
  logic        waiting;

  // Saturating counters: grants per requester, cycles with any unserved req.
  always_comb begin
    waiting    = (req_a && !beat_a) || (req_b && !beat_b);
    grants_a_d = grants_a_q;
    grants_b_d = grants_b_q;
    wait_d     = wait_q;
    if (grant_a && (grants_a_q != 16'hFFFF)) grants_a_d = grants_a_q + 16'd1;
    if (grant_b && (grants_b_q != 16'hFFFF)) grants_b_d = grants_b_q + 16'd1;
    if (waiting && (wait_q     != 16'hFFFF)) wait_d     = wait_q + 16'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grants_a_q <= '0;
      grants_b_q <= '0;
      wait_q     <= '0;
    end else begin
      grants_a_q <= grants_a_d;
      grants_b_q <= grants_b_d;
      wait_q     <= wait_d;
    end
  end

  assign stat_grants_a = grants_a_q;
  assign stat_grants_b = grants_b_q;
  assign stat_wait     = wait_q;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: stimulus pushes expected beats and
// read returns into queues, a negedge monitor pops and compares them.
module tb_ram_port_arbiter;
  localparam int AW = 10;
  localparam int DS = 16;
  localparam int LW = 5;
  localparam int DW = 128;

  logic          clk, reset, preload;
  logic          req_a, req_b, we_a, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [LW-1:0] len_a, len_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic [DS-1:0] wmask_a, wmask_b;
  logic          ack_a, ack_b, beat_a, beat_b, rvalid_a, rvalid_b, busy;
  logic [DW-1:0] rdata, ram_d, ram_q;
  logic [AW-1:0] ram_addr;
  logic [DS-1:0] ram_we;
`ifdef RAM_ARB_STATS_EN
  logic [15:0]   stat_grants_a, stat_grants_b, stat_wait;
`endif

  typedef struct {
    logic          id;
    logic [AW-1:0] addr;
    logic          first;
    logic [DS-1:0] mask;
    logic [DW-1:0] data;
  } beat_t;
  typedef struct {
    logic          id;
    logic [DW-1:0] data;
  } rd_t;

  beat_t         exp_beats[$];
  rd_t           exp_rds[$];
  logic [DW-1:0] mem     [0:1023];
  logic [DW-1:0] exp_mem [0:1023];
  logic [DW-1:0] wbuf    [0:31];
  int            n_vec = 0;
  int            n_err = 0;
  int            wait_model = 0;
  logic          prev_busy = 1'b0;

  ram_port_arbiter dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .len_a(len_a), .len_b(len_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b), .wmask_a(wmask_a), .wmask_b(wmask_b),
    .ack_a(ack_a), .ack_b(ack_b), .beat_a(beat_a), .beat_b(beat_b),
    .rvalid_a(rvalid_a), .rvalid_b(rvalid_b), .rdata(rdata), .busy(busy),
    .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q)
`ifdef RAM_ARB_STATS_EN
    , .stat_grants_a(stat_grants_a), .stat_grants_b(stat_grants_b),
    .stat_wait(stat_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input int i);
    logic [15:0] h;
    h = 16'(i) ^ 16'hC3A0;
    return {8{h}};
  endfunction

  // Tile RAM model: byte-enable write, 1-cycle registered read.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
      ram_q <= '0;
    end else begin
      for (int b = 0; b < DS; b++)
        if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_d[b*8 +: 8];
      ram_q <= mem[ram_addr];
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pop expectations whenever the DUT issues a beat or returns data.
  always @(negedge clk) begin
    if (reset) begin
      prev_busy  = 1'b0;
      wait_model = 0;
    end else begin
      if (beat_a || beat_b) begin
        beat_t e;
        chk("beat_excl", DW'(beat_a && beat_b), '0);
        if (exp_beats.size() == 0) begin
          chk("beat_unexpected", DW'(1), DW'(0));
        end else begin
          e = exp_beats.pop_front();
          chk("beat_id", DW'(beat_b), DW'(e.id));
          chk("beat_addr", DW'(ram_addr), DW'(e.addr));
          chk("beat_ack", DW'({ack_b, ack_a}), DW'({e.first && e.id, e.first && !e.id}));
          chk("beat_we", DW'(ram_we), DW'(e.mask));
          chk("beat_d", ram_d, e.data);
          if (e.first) chk("idle_gap", DW'(prev_busy), '0);
        end
      end else begin
        chk("idle_out", DW'({busy, ack_a, ack_b, ram_we, ram_addr}), '0);
        chk("idle_d", ram_d, '0);
      end
      if (rvalid_a || rvalid_b) begin
        rd_t r;
        chk("rvalid_excl", DW'(rvalid_a && rvalid_b), '0);
        if (exp_rds.size() == 0) begin
          chk("rvalid_unexpected", DW'(1), DW'(0));
        end else begin
          r = exp_rds.pop_front();
          chk("rvalid_id", DW'(rvalid_b), DW'(r.id));
          chk("rdata", rdata, r.data);
        end
      end
      if ((req_a && !beat_a) || (req_b && !beat_b)) wait_model++;
      prev_busy = busy;
    end
  end

  task automatic push_read(input logic id, input logic [AW-1:0] base, input int len,
                           input logic use_lit, input logic [DW-1:0] lit);
    for (int k = 0; k <= len; k++) begin
      logic [AW-1:0] a;
      a = base + AW'(k);
      exp_beats.push_back('{id: id, addr: a, first: (k == 0), mask: '0, data: '0});
      exp_rds.push_back('{id: id, data: use_lit ? lit : exp_mem[a]});
    end
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while ((exp_beats.size() != 0 || exp_rds.size() != 0 || busy) && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    chk("drain", DW'({exp_beats.size() != 0, exp_rds.size() != 0, busy}), '0);
  endtask

  task automatic issue_read(input logic id, input logic [AW-1:0] base, input int len,
                            input logic use_lit, input logic [DW-1:0] lit);
    int cyc = 0;
    logic got = 1'b0;
    push_read(id, base, len, use_lit, lit);
    if (id) begin req_b = 1'b1; we_b = 1'b0; addr_b = base; len_b = LW'(len); end
    else    begin req_a = 1'b1; we_a = 1'b0; addr_a = base; len_a = LW'(len); end
    while (!got && cyc < 100) begin
      @(posedge clk); #1; cyc++;
      got = id ? ack_b : ack_a;
    end
    chk("read_ack", DW'(got), DW'(1));
    req_a = 1'b0; req_b = 1'b0;
    wait_drain();
  endtask

  task automatic write_a(input logic [AW-1:0] base, input int len, input logic [DS-1:0] mask);
    int idx = 0;
    int cyc = 0;
    logic adv, got;
    for (int k = 0; k <= len; k++) begin
      logic [AW-1:0] a;
      a = base + AW'(k);
      exp_beats.push_back('{id: 1'b0, addr: a, first: (k == 0), mask: mask, data: wbuf[k]});
      for (int b = 0; b < DS; b++)
        if (mask[b]) exp_mem[a][b*8 +: 8] = wbuf[k][b*8 +: 8];
    end
    req_a = 1'b1; we_a = 1'b1; addr_a = base; len_a = LW'(len);
    wdata_a = wbuf[0]; wmask_a = mask;
    while (idx <= len && cyc < 100) begin
      @(negedge clk); adv = beat_a; got = ack_a;
      @(posedge clk); #1; cyc++;
      if (got) req_a = 1'b0;
      if (adv) begin
        idx++;
        if (idx <= len) wdata_a = wbuf[idx];
      end
    end
    chk("write_beats", DW'(idx), DW'(len + 1));
    req_a = 1'b0;
    wait_drain();
  endtask

  initial begin
    int acks, cyc, nb;
    logic hit;
    reset = 1'b1; preload = 1'b1;
    req_a = 1'b1; req_b = 1'b1; we_a = 1'b0; we_b = 1'b0;
    addr_a = 10'd100; addr_b = 10'd200; len_a = 5'd3; len_b = 5'd3;
    wdata_a = '0; wdata_b = '0; wmask_a = '0; wmask_b = '0;
    for (int i = 0; i < 1024; i++) exp_mem[i] = pat(i);

    // Round-robin tie held from reset: expect A, B, A, B.
    for (int n = 0; n < 4; n++)
      push_read(n[0], n[0] ? 10'd200 : 10'd100, 3, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1 preload = 1'b0;
    chk("rst_ctl", DW'({busy, ack_a, ack_b, beat_a, beat_b, rvalid_a, rvalid_b}), '0);
    chk("rst_ram", DW'({ram_we, ram_addr}), '0);
    chk("rst_d", ram_d, '0);
    chk("rst_rdata", rdata, '0);
    @(posedge clk); #1 reset = 1'b0;
    acks = 0; cyc = 0;
    while (acks < 4 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
      if (ack_a || ack_b) acks++;
    end
    req_a = 1'b0; req_b = 1'b0;
    chk("tie_acks", DW'(acks), DW'(4));
    wait_drain();
`ifdef RAM_ARB_STATS_EN
    chk("stat_grants_a", DW'(stat_grants_a), DW'(2));
    chk("stat_grants_b", DW'(stat_grants_b), DW'(2));
    chk("stat_wait", DW'(stat_wait), DW'(wait_model));
`endif

    // Write then read 16 random words from address 0.
    for (int k = 0; k < 16; k++) wbuf[k] = {$urandom, $urandom, $urandom, $urandom};
    write_a(10'd0, 15, 16'hFFFF);
    issue_read(1'b0, 10'd0, 15, 1'b0, '0);

    // Address wrap for B: 1022, 1023, 0, 1.
    issue_read(1'b1, 10'd1022, 3, 1'b0, '0);

    // Byte mask: low 8 bytes AA over a word of 11.
    wbuf[0] = {16{8'h11}};
    write_a(10'd5, 0, 16'hFFFF);
    wbuf[0] = {16{8'hAA}};
    write_a(10'd5, 0, 16'h00FF);
    issue_read(1'b0, 10'd5, 0, 1'b1, 128'h1111111111111111_AAAAAAAAAAAAAAAA);

    // Reset during beat 2 of an 8-beat A read.
    push_read(1'b0, 10'd0, 7, 1'b0, '0);
    req_a = 1'b1; we_a = 1'b0; addr_a = 10'd0; len_a = 5'd7;
    nb = 0; cyc = 0; hit = 1'b0;
    while (!hit && cyc < 100) begin
      @(posedge clk); #1; cyc++;
      if (beat_a) begin
        if (nb == 2) hit = 1'b1;
        else nb++;
      end
    end
    chk("mid_burst_reached", DW'(hit), DW'(1));
    reset = 1'b1;
    #1;
    chk("abort_out", DW'({busy, beat_a, beat_b, rvalid_a, rvalid_b, ram_we}), '0);
    exp_beats.delete();
    exp_rds.delete();
    req_a = 1'b1; addr_a = 10'd400; len_a = 5'd1;
    req_b = 1'b1; we_b = 1'b0; addr_b = 10'd300; len_b = 5'd1;
    push_read(1'b0, 10'd400, 1, 1'b0, '0);
    push_read(1'b1, 10'd300, 1, 1'b0, '0);
    @(posedge clk); #1 reset = 1'b0;
    cyc = 0;
    while ((req_a || req_b) && cyc < 100) begin
      @(posedge clk); #1; cyc++;
      if (ack_a) req_a = 1'b0;
      if (ack_b) req_b = 1'b0;
    end
    chk("post_rst_acks", DW'({req_a, req_b}), '0);
    wait_drain();
`ifdef RAM_ARB_STATS_EN
    chk("stat_grants_a_rst", DW'(stat_grants_a), DW'(1));
    chk("stat_grants_b_rst", DW'(stat_grants_b), DW'(1));
    chk("stat_wait_rst", DW'(stat_wait), DW'(wait_model));
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
